// File: rtl/watch_time_core.sv
// 24-hour BCD timekeeping core: 1 Hz prescaler, debounced 3-key input and a
// mode/set state machine feeding a four-digit display driver.
//
// state        | meaning
// ST_RUN       | time counts, display HH MM
// ST_SET_HOUR  | time frozen, UP/DOWN edit hours
// ST_SET_MIN   | time frozen, UP/DOWN edit minutes; MODE restarts the second
// ST_VIEW_MS   | time counts, display MM SS
module watch_time_core #(
    parameter int CLK_FRE = 50_000_000,
    parameter int DEB_CNT = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] key,
    output logic [3:0] hour_h_o,
    output logic [3:0] hour_l_o,
    output logic [3:0] minutes_h_o,
    output logic [3:0] minutes_l_o,
    output logic       second_led,
    output logic [2:0] state_flag
);

    localparam int PW = (CLK_FRE > 1) ? $clog2(CLK_FRE) : 1;
    localparam int DW = $clog2(DEB_CNT + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FRE - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_FRE / 2);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CNT - 1);

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_SET_HOUR = 3'd1,
        ST_SET_MIN  = 3'd2,
        ST_VIEW_MS  = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      key_meta_q, key_sync_q;
    logic [2:0]      stable_q, stable_d;
    logic [DW-1:0]   deb_cnt_q [3];
    logic [DW-1:0]   deb_cnt_d [3];
    logic [PW-1:0]   presc_q, presc_d;
    logic [7:0]      sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic [2:0]      press;
    logic            act_mode, act_up, act_down, running, tick;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        if (v == lim)            return 8'h00;
        else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                     return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lim);
        if (v == 8'h00)          return lim;
        else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        else                     return {v[7:4], v[3:0] - 4'd1};
    endfunction

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 3; i++) begin
            deb_cnt_d[i] = '0;
            if (key_sync_q[i] != stable_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    stable_d[i] = key_sync_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Keys are active-low: a press is a stable 1->0 edge. One action per cycle.
    assign press    = stable_q & ~stable_d;
    assign act_mode = press[0];
    assign act_down = press[2] & ~press[0];
    assign act_up   = press[1] & ~press[0] & ~press[2];

    assign running = (state_q == ST_RUN) || (state_q == ST_VIEW_MS);
    assign tick    = running && (presc_q == PRESC_LAST);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        if (running) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
        if (tick) begin
            sec_d = bcd_inc(sec_q, 8'h59);
            if (sec_q == 8'h59) begin
                min_d = bcd_inc(min_q, 8'h59);
                if (min_q == 8'h59) hour_d = bcd_inc(hour_q, 8'h23);
            end
        end
        case (state_q)
            ST_RUN: begin
                if (act_mode)      state_d = ST_SET_HOUR;
                else if (act_down) state_d = ST_VIEW_MS;
            end
            ST_VIEW_MS: begin
                if (act_mode || act_down) state_d = ST_RUN;
            end
            ST_SET_HOUR: begin
                if (act_mode)      state_d = ST_SET_MIN;
                else if (act_up)   hour_d  = bcd_inc(hour_q, 8'h23);
                else if (act_down) hour_d  = bcd_dec(hour_q, 8'h23);
            end
            ST_SET_MIN: begin
                if (act_mode) begin
                    state_d = ST_RUN;
                    sec_d   = 8'h00;
                    presc_d = '0;
                end else if (act_up) begin
                    min_d = bcd_inc(min_q, 8'h59);
                end else if (act_down) begin
                    min_d = bcd_dec(min_q, 8'h59);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_meta_q <= 3'b111;
            key_sync_q <= 3'b111;
            stable_q   <= 3'b111;
            for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
            state_q    <= ST_RUN;
            presc_q    <= '0;
            sec_q      <= 8'h00;
            min_q      <= 8'h00;
            hour_q     <= 8'h00;
        end else begin
            key_meta_q <= key;
            key_sync_q <= key_meta_q;
            stable_q   <= stable_d;
            for (int i = 0; i < 3; i++) deb_cnt_q[i] <= deb_cnt_d[i];
            state_q    <= state_d;
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
        end
    end

    // VIEW_MS shifts the display one field right to show minutes and seconds.
    always_comb begin
        if (state_q == ST_VIEW_MS) begin
            {hour_h_o, hour_l_o}       = min_q;
            {minutes_h_o, minutes_l_o} = sec_q;
        end else begin
            {hour_h_o, hour_l_o}       = hour_q;
            {minutes_h_o, minutes_l_o} = min_q;
        end
    end

    assign second_led = (presc_q < PRESC_HALF);
    assign state_flag = state_q;

endmodule

// File: tb/tb_watch_time_core.sv
// Self-checking bench for watch_time_core: randomized key presses compared
// against an integer seconds/state reference model.
module tb_watch_time_core;

    localparam int CF = 20;
    localparam int DB = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] key = 3'b111;
    logic [3:0] hour_h_o, hour_l_o, minutes_h_o, minutes_l_o;
    logic       second_led;
    logic [2:0] state_flag;

    watch_time_core #(.CLK_FRE(CF), .DEB_CNT(DB)) dut (
        .clk         (clk),
        .rst         (rst),
        .key         (key),
        .hour_h_o    (hour_h_o),
        .hour_l_o    (hour_l_o),
        .minutes_h_o (minutes_h_o),
        .minutes_l_o (minutes_l_o),
        .second_led  (second_led),
        .state_flag  (state_flag)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int m_h, m_m, m_s, m_presc, m_st;

    wire [22:0] dut_vec = {hour_h_o, hour_l_o, minutes_h_o, minutes_l_o, state_flag, second_led};
    wire [15:0] dut_dig = {hour_h_o, hour_l_o, minutes_h_o, minutes_l_o};

    function automatic logic [22:0] model_vec();
        int a, b;
        if (m_st == 5) begin a = m_m; b = m_s; end
        else           begin a = m_h; b = m_m; end
        return {4'(a / 10), 4'(a % 10), 4'(b / 10), 4'(b % 10), 3'(m_st), 1'(m_presc < CF / 2)};
    endfunction

    function automatic int prio(input logic [2:0] b);
        if (b[0]) return 1;
        if (b[2]) return 3;
        if (b[1]) return 2;
        return 0;
    endfunction

    // act: 0 none, 1 MODE, 2 UP, 3 DOWN/VIEW, applied on this edge
    task automatic cycle(input int act);
        int t;
        @(posedge clk);
        #1;
        if (rst) begin
            m_h = 0; m_m = 0; m_s = 0; m_presc = 0; m_st = 0;
        end else begin
            if (m_st == 0 || m_st == 5) begin
                m_presc++;
                if (m_presc == CF) begin
                    m_presc = 0;
                    t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
                    m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
                end
            end
            case (act)
                1: case (m_st)
                       0: m_st = 1;
                       5: m_st = 0;
                       1: m_st = 2;
                       2: begin m_st = 0; m_s = 0; m_presc = 0; end
                       default: ;
                   endcase
                2: if (m_st == 1) m_h = (m_h + 1) % 24;
                   else if (m_st == 2) m_m = (m_m + 1) % 60;
                3: case (m_st)
                       0: m_st = 5;
                       5: m_st = 0;
                       1: m_h = (m_h + 23) % 24;
                       2: m_m = (m_m + 59) % 60;
                       default: ;
                   endcase
                default: ;
            endcase
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle(0);
    endtask

    // Key bits b held low for `low` cycles, then released for `idle` cycles.
    // A press lands 2 sync + DB debounce cycles after the key falls.
    task automatic press(input logic [2:0] b, input int low, input int idle);
        key = ~b;
        for (int i = 1; i <= low + idle; i++) begin
            cycle((i == DB + 2 && low >= DB) ? prio(b) : 0);
            if (i == low) key = 3'b111;
        end
    endtask

    task automatic tap(input logic [2:0] b, input int n);
        repeat (n) press(b, 4, 8);
    endtask

    task automatic do_reset();
        key = 3'b111;
        rst = 1'b1;
        cycle(0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (dut_vec !== 23'h000001) begin
            n_err++; $display("FAIL reset_state: dut=%h want=%h", dut_vec, 23'h000001);
        end
        for (int i = 0; i < CF; i++) begin
            n_cmp++;
            if (second_led !== 1'(i < CF / 2) || dut_vec !== model_vec()) begin
                n_err++; $display("FAIL led_phase%0d: dut=%h want=%h", i, dut_vec, model_vec());
            end
            cycle(0);
        end
        tap(3'b100, 1);
        n_cmp++;
        if (dut_vec !== model_vec() || dut_dig !== 16'h0001) begin
            n_err++; $display("FAIL first_second: dut=%h want=%h", dut_vec, model_vec());
        end
        tap(3'b100, 1);
    endtask

    task automatic test_rollover();
        do_reset();
        tap(3'b001, 1); tap(3'b100, 1); tap(3'b001, 1); tap(3'b100, 1); tap(3'b001, 1);
        run(58 * CF);
        n_cmp++;
        if (dut_dig !== 16'h2359 || dut_vec !== model_vec() || m_s != 58) begin
            n_err++; $display("FAIL pre_roll: dut=%h want=%h s=%0d", dut_vec, model_vec(), m_s);
        end
        run(2 * CF);
        n_cmp++;
        if (dut_dig !== 16'h0000 || dut_vec !== model_vec()) begin
            n_err++; $display("FAIL day_roll: dut=%h want=%h", dut_vec, model_vec());
        end
        tap(3'b100, 1);
        n_cmp++;
        if (dut_dig !== 16'h0000 || state_flag !== 3'd5 || dut_vec !== model_vec()) begin
            n_err++; $display("FAIL roll_view: dut=%h want=%h", dut_vec, model_vec());
        end
        do_reset();
        tap(3'b001, 2); tap(3'b010, 9); tap(3'b001, 1);
        run(60 * CF);
        n_cmp++;
        if (dut_dig !== 16'h0010 || dut_vec !== model_vec()) begin
            n_err++; $display("FAIL min_carry: dut=%h want=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_set();
        do_reset();
        tap(3'b001, 1); tap(3'b100, 2);
        n_cmp++;
        if (dut_dig !== 16'h2200 || dut_vec !== model_vec()) begin
            n_err++; $display("FAIL set_22: dut=%h want=%h", dut_vec, model_vec());
        end
        tap(3'b010, 6);
        n_cmp++;
        if (dut_dig !== 16'h0400 || dut_vec !== model_vec()) begin
            n_err++; $display("FAIL hour_wrap_up: dut=%h want=%h", dut_vec, model_vec());
        end
        tap(3'b100, 5);
        n_cmp++;
        if (dut_dig !== 16'h2300 || dut_vec !== model_vec()) begin
            n_err++; $display("FAIL hour_wrap_down: dut=%h want=%h", dut_vec, model_vec());
        end
        run(3 * CF);
        tap(3'b001, 1); tap(3'b100, 1);
        n_cmp++;
        if (dut_dig !== 16'h2359 || state_flag !== 3'd2 || dut_vec !== model_vec()) begin
            n_err++; $display("FAIL min_wrap_down: dut=%h want=%h", dut_vec, model_vec());
        end
        tap(3'b001, 1); tap(3'b100, 1);
        n_cmp++;
        if (dut_dig !== 16'h5900 || state_flag !== 3'd5 || dut_vec !== model_vec()) begin
            n_err++; $display("FAIL exit_set_sec0: dut=%h want=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_debounce();
        do_reset();
        press(3'b001, 2, 10);
        press(3'b001, 1, 10);
        n_cmp++;
        if (state_flag !== 3'd0 || dut_vec !== model_vec()) begin
            n_err++; $display("FAIL glitch: dut=%h want=%h", dut_vec, model_vec());
        end
        press(3'b001, 3, 10);
        n_cmp++;
        if (state_flag !== 3'd1 || dut_vec !== model_vec()) begin
            n_err++; $display("FAIL min_hold: dut=%h want=%h", dut_vec, model_vec());
        end
        press(3'b010, 100, 10);
        n_cmp++;
        if (dut_dig !== 16'h0100 || dut_vec !== model_vec()) begin
            n_err++; $display("FAIL long_hold: dut=%h want=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_view();
        do_reset();
        run(3 * CF + 7);
        tap(3'b100, 1);
        n_cmp++;
        if (state_flag !== 3'd5 || dut_dig !== 16'h0003 || dut_vec !== model_vec()) begin
            n_err++; $display("FAIL view_on: dut=%h want=%h", dut_vec, model_vec());
        end
        tap(3'b100, 1);
        n_cmp++;
        if (state_flag !== 3'd0 || dut_vec !== model_vec()) begin
            n_err++; $display("FAIL view_off: dut=%h want=%h", dut_vec, model_vec());
        end
        tap(3'b001, 1);
        press(3'b011, 4, 8);
        n_cmp++;
        if (state_flag !== 3'd2 || dut_dig !== 16'h0000 || dut_vec !== model_vec()) begin
            n_err++; $display("FAIL mode_beats_up: dut=%h want=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tap(3'b001, 1); tap(3'b010, 12); tap(3'b001, 1); tap(3'b010, 34);
        n_cmp++;
        if (dut_dig !== 16'h1234 || state_flag !== 3'd2 || dut_vec !== model_vec()) begin
            n_err++; $display("FAIL set_1234: dut=%h want=%h", dut_vec, model_vec());
        end
        key = 3'b110;
        run(3);
        rst = 1'b1;
        cycle(0);
        rst = 1'b0;
        key = 3'b111;
        n_cmp++;
        if (dut_vec !== 23'h000001) begin
            n_err++; $display("FAIL reset_mid_edit: dut=%h want=%h", dut_vec, 23'h000001);
        end
        run(12);
        n_cmp++;
        if (state_flag !== 3'd0 || dut_vec !== model_vec()) begin
            n_err++; $display("FAIL reset_mid_deb: dut=%h want=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_random();
        logic [2:0] b;
        int low;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            b   = 3'($urandom_range(1, 7));
            low = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : $urandom_range(3, 12);
            press(b, low, $urandom_range(6, 25));
            if ($urandom_range(0, 2) == 0) run($urandom_range(0, 3 * CF));
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_err++; $display("FAIL random%0d: dut=%h want=%h", it, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_set();
        test_debounce();
        test_view();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
